// File: rtl/des_if.sv
// des_if -- block/key/direction bundle for the DES core.
// The master presents key, plaintext and encrypt.
// The slave returns the registered ciphertext and the key parity flags.
interface des_if;
    logic [63:0] key;
    logic [63:0] plaintext;
    logic        encrypt;
    logic [7:0]  OddParity;
    logic [63:0] ciphertext;

    modport master (output key, plaintext, encrypt, input OddParity, ciphertext);
    modport slave  (input key, plaintext, encrypt, output OddParity, ciphertext);
endinterface

// File: rtl/des.sv
// des -- single-block DES (ECB). A fully combinational 16-round datapath
// feeds a 1-cycle output register, so a new block is accepted every cycle.
// Build macro DES_PARITY_CHECK_EN: when defined, OddParity reports per-byte
// key parity (1 = odd/valid). When undefined, the parity logic is left out
// and OddParity reads 8'hFF out of reset.
// Tables use FIPS numbering: bit 1 is the MSB of each vector.
module des (
    input  logic clk,
    input  logic reset_n,
    des_if.slave bus
);

    localparam int IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
    localparam int FP_T [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};
    localparam int E_T [48] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,  8,  9, 10, 11,
        12, 13, 12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21,
        22, 23, 24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};
    localparam int P_T [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};
    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10, 23, 19, 12,  4,
        26,  8, 16,  7, 27, 20, 13,  2, 41, 52, 31, 37, 47, 55, 30, 40,
        51, 45, 33, 48, 44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
    // Cumulative C/D left rotation reached at each round (1,1,2,2,... summed).
    localparam int ROT_T [16] = '{1, 2, 4, 6, 8, 10, 12, 14, 15, 17, 19, 21, 23, 25, 27, 28};
    // S1..S8 flattened: index = {box[2:0], row[1:0], col[3:0]}.
    localparam int SBOX_T [512] = '{
        14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,  0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
         4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0, 15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13,
        15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,  3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
         0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15, 13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9,
        10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8, 13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
        13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,  1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12,
         7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15, 13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
        10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,  3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14,
         2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9, 14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
         4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14, 11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3,
        12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11, 10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
         9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,  4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13,
         4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1, 13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
         1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,  6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12,
        13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,  1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
         7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,  2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11};

    // Round subkey: rotate both 28-bit halves by the cumulative amount, then PC-2.
    function automatic logic [47:0] f_subkey(input logic [55:0] cd, input int rot);
        logic [27:0] c;
        logic [27:0] d;
        logic [55:0] cd_rot;
        logic [47:0] k;
        c      = cd[55:28];
        d      = cd[27:0];
        c      = (c << rot) | (c >> (28 - rot));
        d      = (d << rot) | (d >> (28 - rot));
        cd_rot = {c, d};
        k      = '0;
        for (int i = 0; i < 48; i++) k = {k[46:0], cd_rot[6'(56 - PC2_T[i])]};
        return k;
    endfunction

    // Feistel function: E expansion, subkey mix, S-boxes, P.
    function automatic logic [31:0] f_round(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] e;
        logic [31:0] s;
        logic [31:0] p;
        logic [5:0]  six;
        e = '0;
        s = '0;
        p = '0;
        for (int i = 0; i < 48; i++) e = {e[46:0], r[5'(32 - E_T[i])]};
        e = e ^ k;
        for (int j = 0; j < 8; j++) begin
            six = e[6'(42 - 6 * j) +: 6];
            s   = {s[27:0], 4'(SBOX_T[{3'(j), six[5], six[0], six[4:1]}])};
        end
        for (int i = 0; i < 32; i++) p = {p[30:0], s[5'(32 - P_T[i])]};
        return p;
    endfunction

    // Full block: PC-1 drops the parity bits, decryption only reverses subkey order.
    function automatic logic [63:0] f_des(input logic [63:0] key, input logic [63:0] blk,
                                          input logic enc);
        logic [55:0] cd;
        logic [63:0] ipd;
        logic [63:0] pre;
        logic [63:0] res;
        logic [31:0] l;
        logic [31:0] r;
        logic [31:0] t;
        int          kidx;
        cd  = '0;
        ipd = '0;
        res = '0;
        for (int i = 0; i < 56; i++) cd  = {cd[54:0], key[6'(64 - PC1_T[i])]};
        for (int i = 0; i < 64; i++) ipd = {ipd[62:0], blk[6'(64 - IP_T[i])]};
        l = ipd[63:32];
        r = ipd[31:0];
        for (int rnd = 0; rnd < 16; rnd++) begin
            kidx = enc ? rnd : 15 - rnd;
            t    = r;
            r    = l ^ f_round(r, f_subkey(cd, ROT_T[kidx]));
            l    = t;
        end
        pre = {r, l};
        for (int i = 0; i < 64; i++) res = {res[62:0], pre[6'(64 - FP_T[i])]};
        return res;
    endfunction

    logic [63:0] w_result;
    logic [7:0]  w_parity;
    logic [63:0] r_ciphertext;
    logic [7:0]  r_parity;

    // Whole 16-round cipher evaluated on the inputs currently presented.
    always_comb w_result = f_des(bus.key, bus.plaintext, bus.encrypt);

`ifdef DES_PARITY_CHECK_EN
    // One XOR tree per key byte; 1 means that byte has odd (valid) parity.
    always_comb begin
        w_parity = '0;
        for (int i = 0; i < 8; i++) w_parity[i] = ^bus.key[8*i +: 8];
    end
`else
    assign w_parity = 8'hFF;
`endif

    // Output register; reset clears any in-flight result.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ciphertext <= '0;
            r_parity     <= '0;
        end else begin
            r_ciphertext <= w_result;
            r_parity     <= w_parity;
        end
    end

    assign bus.ciphertext = r_ciphertext;
    assign bus.OddParity  = r_parity;

endmodule

// File: tb/tb_des.sv
// tb_des -- self-checking bench for the DES core: known answers, back-to-back
// streaming, asynchronous reset, random regression and round trips against a
// bit-array reference model written directly from the FIPS 46 tables.
module tb_des;

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;
    logic [63:0] exp_q;

    des_if bus ();

    des dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef DES_PARITY_CHECK_EN
    localparam logic [7:0] ZERO_KEY_PAR = 8'h00;
`else
    localparam logic [7:0] ZERO_KEY_PAR = 8'hFF;
`endif

    localparam int IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
    localparam int FP_T [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};
    localparam int E_T [48] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,  8,  9, 10, 11,
        12, 13, 12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21,
        22, 23, 24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};
    localparam int P_T [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};
    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10, 23, 19, 12,  4,
        26,  8, 16,  7, 27, 20, 13,  2, 41, 52, 31, 37, 47, 55, 30, 40,
        51, 45, 33, 48, 44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
    localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
    localparam int SB_T [512] = '{
        14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,  0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
         4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0, 15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13,
        15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,  3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
         0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15, 13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9,
        10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8, 13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
        13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,  1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12,
         7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15, 13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
        10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,  3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14,
         2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9, 14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
         4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14, 11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3,
        12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11, 10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
         9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,  4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13,
         4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1, 13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
         1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,  6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12,
        13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,  1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
         7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,  2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11};

    localparam logic [63:0] KAT_KEY [4] = '{64'h133457799BBCDFF1, 64'h133457799BBCDFF1,
                                            64'h0E329232EA6D0D73, 64'h0000000000000000};
    localparam logic [63:0] KAT_PT  [4] = '{64'h0123456789ABCDEF, 64'h85E813540F0AB405,
                                            64'h8787878787878787, 64'h0000000000000000};
    localparam logic [63:0] KAT_CT  [4] = '{64'h85E813540F0AB405, 64'h0123456789ABCDEF,
                                            64'h0000000000000000, 64'h8CA64DE9C1B123A7};
    localparam logic        KAT_ENC [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    localparam logic [7:0]  KAT_PAR [4] = '{8'hFF, 8'hFF, 8'hFF, ZERO_KEY_PAR};

    // Reference DES over FIPS-numbered bit arrays (index 1 = leftmost bit);
    // subkeys are built by iterated single-bit rotations and stored K1..K16.
    function automatic logic [63:0] ref_des(input logic [63:0] key, input logic [63:0] blk,
                                            input logic enc);
        bit kb [1:64];
        bit db [1:64];
        bit c [1:28];
        bit d [1:28];
        bit ks [1:16][1:48];
        bit lh [1:32];
        bit rh [1:32];
        bit nr [1:32];
        bit ex [1:48];
        bit so [1:32];
        bit pre [1:64];
        bit tmp;
        int row, col, v, kr, b6;
        logic [63:0] res;
        res = '0;
        for (int n = 1; n <= 64; n++) begin
            kb[n] = key[6'(64 - n)];
            db[n] = blk[6'(64 - n)];
        end
        for (int i = 1; i <= 28; i++) begin
            c[i] = kb[PC1_T[i - 1]];
            d[i] = kb[PC1_T[i + 27]];
        end
        for (int rd = 1; rd <= 16; rd++) begin
            for (int s = 0; s < SHIFTS[rd - 1]; s++) begin
                tmp = c[1];
                for (int i = 1; i < 28; i++) c[i] = c[i + 1];
                c[28] = tmp;
                tmp = d[1];
                for (int i = 1; i < 28; i++) d[i] = d[i + 1];
                d[28] = tmp;
            end
            for (int j = 1; j <= 48; j++)
                ks[rd][j] = (PC2_T[j - 1] <= 28) ? c[PC2_T[j - 1]] : d[PC2_T[j - 1] - 28];
        end
        for (int i = 1; i <= 32; i++) begin
            lh[i] = db[IP_T[i - 1]];
            rh[i] = db[IP_T[i + 31]];
        end
        for (int rd = 1; rd <= 16; rd++) begin
            kr = enc ? rd : 17 - rd;
            for (int j = 1; j <= 48; j++) ex[j] = rh[E_T[j - 1]] ^ ks[kr][j];
            for (int b = 0; b < 8; b++) begin
                b6  = 6 * b;
                row = 2 * int'(ex[b6 + 1]) + int'(ex[b6 + 6]);
                col = 8 * int'(ex[b6 + 2]) + 4 * int'(ex[b6 + 3]) + 2 * int'(ex[b6 + 4]) + int'(ex[b6 + 5]);
                v   = SB_T[64 * b + 16 * row + col];
                for (int q = 0; q < 4; q++) so[4 * b + 1 + q] = bit'((v >> (3 - q)) & 1);
            end
            for (int i = 1; i <= 32; i++) nr[i] = lh[i] ^ so[P_T[i - 1]];
            lh = rh;
            rh = nr;
        end
        for (int i = 1; i <= 32; i++) begin
            pre[i]      = rh[i];
            pre[i + 32] = lh[i];
        end
        for (int i = 1; i <= 64; i++) res[6'(64 - i)] = pre[FP_T[i - 1]];
        return res;
    endfunction

    // A byte is valid when its population count is odd.
    function automatic logic [7:0] ref_parity(input logic [63:0] key);
        logic [7:0] p;
        p = 8'hFF;
`ifdef DES_PARITY_CHECK_EN
        for (int i = 0; i < 8; i++) p[i] = (($countones(key[8*i +: 8]) % 2) == 1);
`endif
        return p;
    endfunction

    task automatic drive(input logic [63:0] k, input logic [63:0] p, input logic e);
        bus.key       = k;
        bus.plaintext = p;
        bus.encrypt   = e;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        drive(KAT_KEY[0], KAT_PT[0], KAT_ENC[0]);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.ciphertext !== 64'h0) begin
            errors++;
            $display("FAIL reset_ct got %h expected %h", bus.ciphertext, 64'h0);
        end
        checks++;
        if (bus.OddParity !== 8'h00) begin
            errors++;
            $display("FAIL reset_par got %h expected %h", bus.OddParity, 8'h00);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.ciphertext !== KAT_CT[0]) begin
            errors++;
            $display("FAIL first_edge_ct got %h expected %h", bus.ciphertext, KAT_CT[0]);
        end
        checks++;
        if (bus.OddParity !== KAT_PAR[0]) begin
            errors++;
            $display("FAIL first_edge_par got %h expected %h", bus.OddParity, KAT_PAR[0]);
        end
        exp_q = KAT_CT[0];
    endtask

    task automatic test_known_answer;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(KAT_KEY[i], KAT_PT[i], KAT_ENC[i]);
            @(posedge clk);
            #1;
            checks++;
            if (bus.ciphertext !== KAT_CT[i]) begin
                errors++;
                $display("FAIL kat_ct[%0d] got %h expected %h", i, bus.ciphertext, KAT_CT[i]);
            end
            checks++;
            if (bus.OddParity !== KAT_PAR[i]) begin
                errors++;
                $display("FAIL kat_par[%0d] got %h expected %h", i, bus.OddParity, KAT_PAR[i]);
            end
            exp_q = KAT_CT[i];
        end
    endtask

    // New inputs every cycle; before each edge the previous result must hold.
    task automatic test_back_to_back;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(KAT_KEY[i], KAT_PT[i], KAT_ENC[i]);
            #1;
            checks++;
            if (bus.ciphertext !== exp_q) begin
                errors++;
                $display("FAIL b2b_hold[%0d] got %h expected %h", i, bus.ciphertext, exp_q);
            end
            @(posedge clk);
            #1;
            checks++;
            if (bus.ciphertext !== KAT_CT[i]) begin
                errors++;
                $display("FAIL b2b_ct[%0d] got %h expected %h", i, bus.ciphertext, KAT_CT[i]);
            end
            exp_q = KAT_CT[i];
        end
    endtask

    task automatic test_reset_midstream;
        @(negedge clk);
        drive(KAT_KEY[1], KAT_PT[1], KAT_ENC[1]);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (bus.ciphertext !== 64'h0) begin
            errors++;
            $display("FAIL midrst_ct got %h expected %h", bus.ciphertext, 64'h0);
        end
        checks++;
        if (bus.OddParity !== 8'h00) begin
            errors++;
            $display("FAIL midrst_par got %h expected %h", bus.OddParity, 8'h00);
        end
        drive(KAT_KEY[0], KAT_PT[0], KAT_ENC[0]);
        @(posedge clk);
        #1;
        checks++;
        if (bus.ciphertext !== 64'h0) begin
            errors++;
            $display("FAIL midrst_hold got %h expected %h", bus.ciphertext, 64'h0);
        end
        @(negedge clk);
        #2;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.ciphertext !== KAT_CT[0]) begin
            errors++;
            $display("FAIL midrst_resume got %h expected %h", bus.ciphertext, KAT_CT[0]);
        end
        exp_q = KAT_CT[0];
    endtask

    task automatic test_random;
        logic [63:0] k, p, e_ct;
        logic        e;
        logic [7:0]  e_par;
        for (int n = 0; n < 512; n++) begin
            k     = {$urandom, $urandom};
            p     = {$urandom, $urandom};
            e     = 1'($urandom);
            e_ct  = ref_des(k, p, e);
            e_par = ref_parity(k);
            @(negedge clk);
            drive(k, p, e);
            @(posedge clk);
            #1;
            checks++;
            if (bus.ciphertext !== e_ct) begin
                errors++;
                $display("FAIL rand_ct[%0d] got %h expected %h", n, bus.ciphertext, e_ct);
            end
            checks++;
            if (bus.OddParity !== e_par) begin
                errors++;
                $display("FAIL rand_par[%0d] got %h expected %h", n, bus.OddParity, e_par);
            end
        end
    endtask

    task automatic test_round_trip;
        logic [63:0] k, p, ct;
        for (int n = 0; n < 32; n++) begin
            k  = {$urandom, $urandom};
            p  = {$urandom, $urandom};
            ct = ref_des(k, p, 1'b1);
            @(negedge clk);
            drive(k, p, 1'b1);
            @(posedge clk);
            #1;
            checks++;
            if (bus.ciphertext !== ct) begin
                errors++;
                $display("FAIL trip_enc[%0d] got %h expected %h", n, bus.ciphertext, ct);
            end
            @(negedge clk);
            drive(k, ct, 1'b0);
            @(posedge clk);
            #1;
            checks++;
            if (bus.ciphertext !== p) begin
                errors++;
                $display("FAIL trip_dec[%0d] got %h expected %h", n, bus.ciphertext, p);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        exp_q  = '0;
        test_reset();
        test_known_answer();
        test_back_to_back();
        test_reset_midstream();
        test_random();
        test_round_trip();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/des.md
DES -- requirements
Module: DES

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-004 key  input  64  DES key; FIPS 46 bit 1 = key[63]; the LSB of each byte is a parity bit.
REQ-005 plaintext  input  64  input data block; bit 1 = plaintext[63]; treated as ciphertext when decrypting.
REQ-006 encrypt  input  1  1 = encrypt, 0 = decrypt.
REQ-007 OddParity  output  8  per-byte key parity flags; OddParity[i] covers key[8i+7:8i].
REQ-008 ciphertext  output  64  result block; bit 1 = ciphertext[63].

Function
REQ-009 The block SHALL implement single-block DES (FIPS 46-3) in ECB mode as one combinational 16-round datapath feeding an output register.
- Sequence: IP, 16 Feistel rounds (E expansion, XOR with subkey, S1-S8, P), swap of the final halves, IP^-1.
REQ-010 The key schedule SHALL apply PC-1 (56 bits, parity bits dropped), then per-round left rotates of C/D by 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1, then PC-2 to give 48-bit subkeys K1..K16.
REQ-011 With encrypt=1, rounds SHALL use K1..K16 in order; with encrypt=0, rounds SHALL use K16..K1; no other datapath difference.
REQ-012 On each rising clk edge with reset_n high, ciphertext SHALL load DES(key, plaintext, encrypt) computed from the inputs sampled at that edge.
- Latency: exactly 1 cycle.
- Throughput: one new block every cycle.
- No handshake: inputs are sampled every cycle.
REQ-013 On each rising clk edge with reset_n high, OddParity[i] SHALL load the XOR of key[8i+7:8i].
- 1 = byte i has odd parity (valid); 0 = parity error.
- OddParity == 8'hFF means the key is fully valid.
REQ-014 Parity errors SHALL NOT block or alter encryption; parity bits never enter the key schedule.
REQ-015 Input changes between clock edges SHALL NOT affect the outputs until the next rising edge.
REQ-016 Weak and semi-weak keys SHALL receive no special handling.

Reset
REQ-017 While reset_n is low, ciphertext SHALL be 64'h0 and OddParity SHALL be 8'h00, asynchronously and regardless of clk.
REQ-018 The first rising edge after reset_n deasserts SHALL load normally per REQ-012/013.
- No extra flush cycle.
REQ-019 Asserting reset mid-stream SHALL discard the in-flight result.
- There is no other state to clear.

Configuration
REQ-020 Macro DES_PARITY_CHECK_EN controls parity checking.
- Defined: OddParity behaves per REQ-013.
- Not defined: OddParity SHALL be 8'hFF whenever reset_n is high, and the parity logic SHALL be omitted.
- Not defined: OddParity still resets to 8'h00.
- The ciphertext function is identical in both builds.

Verification
REQ-021 Known-answer encrypt: key 133457799BBCDFF1, plaintext 0123456789ABCDEF, encrypt=1 -> ciphertext 85E813540F0AB405 one cycle later, OddParity FF.
REQ-022 Known-answer decrypt: key 133457799BBCDFF1, plaintext 85E813540F0AB405, encrypt=0 -> ciphertext 0123456789ABCDEF.
REQ-023 Key 0E329232EA6D0D73, plaintext 8787878787878787, encrypt=1 -> ciphertext 0000000000000000, OddParity FF.
REQ-024 Parity: key 0000000000000000, plaintext 0000000000000000, encrypt=1 -> ciphertext 8CA64DE9C1B123A7, OddParity 00 (FF if DES_PARITY_CHECK_EN is undefined).
REQ-025 Back-to-back and reset checks:
- New vectors every cycle (REQ-021 then REQ-022 then REQ-023) -> each result appears exactly one cycle after its inputs.
- reset_n pulsed low mid-clock -> ciphertext 0 and OddParity 00 immediately.
- Correct results resume on the first edge after release.
REQ-026 Random regression: at least 512 random key/plaintext/encrypt vectors compared against a reference DES model, plus an encrypt-then-decrypt round trip returning the original plaintext; zero mismatches required.
